nec_prefetch_queue: RTL and testbench
=====================================

Name: nec_prefetch_queue

Overview:
Parametrised instruction prefetch queue for the NEC core front end. It sits between the bus interface unit and the pre-decoder. It issues sequential code fetches from its own fetch pointer and buffers the returned bytes in a circular queue. It presents a byte window that the pre-decoder consumes a variable number of bytes from per cycle, up to the pre-decoded instruction size. Successor to the fixed 6-byte queue: depth, bus width and window size are all parameters, and it adds flush-with-discard of in-flight fetches.

Parameters:
DEPTH, 8, queue capacity in bytes; power of two, minimum 4
BUS_BYTES, 2, fetch data width in bytes; 1 or 2
WINDOW, 6, bytes exposed to the pre-decoder; WINDOW <= DEPTH
CNT_W, $clog2(DEPTH+1), width of byte-count signals

Ports:
clk  in  1  core clock
reset_n  in  1  synchronous reset, active low
fetch_req  out  1  fetch request to bus unit; held until fetch_ack
fetch_addr  out  16  PS-relative fetch offset (PFP); stable while fetch_req=1
fetch_ack  in  1  fetch complete; fetch_data valid this cycle
fetch_data  in  8*BUS_BYTES  fetched bytes; lane k = byte at address (fetch_addr & ~(BUS_BYTES-1)) + k
flush  in  1  discard queue and restart fetch at flush_pc (branch, PS load, interrupt)
flush_pc  in  16  new fetch offset
win_data  out  8*WINDOW  byte i = queue[rd_ptr+i] for i < win_count, else 0
win_count  out  CNT_W  valid bytes in window = min(count, WINDOW)
consume  in  1  pre-decoder retires bytes this cycle
consume_count  in  CNT_W  bytes retired; must be 1..win_count

Behaviour:
- Reset (reset_n=0 at clk edge):
  - fetch_req=0, fetch_addr=0, count=0, rd_ptr=wr_ptr=0, discard=0.
  - win_count=0 and win_data=0.
  - Reset mid-fetch abandons the request. The bus unit is reset on the same reset_n.
- Storage: DEPTH x 8 register array with rd_ptr and wr_ptr of $clog2(DEPTH) bits. Pointers wrap modulo DEPTH.
- win_data and win_count are combinational from storage, pointers and count.
- Fetch bytes per ack: n = BUS_BYTES - (fetch_addr mod BUS_BYTES).
  - With BUS_BYTES=2 and an odd address, only the high lane is written, so n=1.
- Request FSM states:
  - IDLE -> REQ when (DEPTH - count) >= BUS_BYTES and no flush. fetch_req is registered, so it rises the cycle after the condition holds.
  - REQ: fetch_req=1, fetch_addr held. On fetch_ack:
    - If not discarding, write n bytes at wr_ptr, wr_ptr += n, count += n, fetch_addr += n (16-bit wrap).
    - Go to IDLE in all cases.
  - fetch_req is low for at least one cycle after every ack. Max throughput is one fetch per 2 cycles.
- Consume: count -= consume_count and rd_ptr += consume_count.
  - Bytes from an ack appear in the window the cycle after the ack.
  - Ack and consume in the same cycle: both apply; count = count + n - consume_count.
  - consume_count=0 or consume_count > win_count is illegal. Guard with an assertion; RTL behaviour is undefined.
- Flush (highest priority):
  - Next cycle: count=0, rd_ptr=wr_ptr=0, fetch_addr=flush_pc; consume ignored that cycle.
  - If in REQ without ack, set discard=1. fetch_req stays high with the old address until ack; that data is dropped; discard clears. The FSM then enters IDLE and re-requests at flush_pc.
  - Flush in the same cycle as an ack: ack data dropped, discard not set.
- Full: no request is issued while free < BUS_BYTES. An ack can never overflow, since free only grows while a request is outstanding.
- Empty: win_count=0; the pre-decoder must not assert consume.

Optional Feature:
Macro PREFETCH_PERF_EN.
- Defined: adds outputs perf_flush_cnt[15:0] and perf_starve_cnt[15:0].
  - perf_flush_cnt counts flush cycles.
  - perf_starve_cnt counts cycles with win_count=0 and fetch_req=1.
  - Both saturate at 16'hFFFF and reset to 0.
- Undefined: ports and logic absent; no other behaviour differs.

Test Plan:
1. Reset, then idle bus with acks 1 cycle after each req, from PFP 0x0000, data 0x3412,0x7856,0xBC9A. Expect win_count 2,4,6 and win_data = 12 34 56 78 9A BC.
2. Flush to 0x0101. Expect first fetch_addr=0x0101; ack data 0xEEFF writes only byte 0xEE, win_count=1; next fetch_addr=0x0102.
3. Fill to count=8 with no consume. Expect fetch_req stays 0. consume_count=3 gives count=5 and win_count=5, and fetch_req rises the next cycle.
4. Ack (+2) and consume_count=2 in the same cycle at count=4. Expect count stays 4 and rd_ptr and wr_ptr advance by 2.
5. Flush to 0x2000 while REQ at 0x0010, ack 3 cycles later with 0xAAAA. Expect win_count stays 0 and the next fetch_addr=0x2000.
6. Pointer wrap: consume and fetch continuously for 20 fetches. Expect win_data bytes to match the address-sequential reference model across rd_ptr wrap.

Source files
------------

// File: rtl/nec_prefetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : nec_prefetch_queue
// Brief    : Parametrised instruction prefetch queue for the NEC front end.
//            Issues sequential code fetches from its own fetch pointer (PFP),
//            buffers the returned bytes in a circular byte queue and exposes
//            a WINDOW-byte view to the pre-decoder. The pre-decoder retires a
//            variable number of bytes per cycle. A flush restarts fetching at
//            a new offset and discards any fetch still in flight.
// Options  : PREFETCH_PERF_EN adds perf_flush_cnt / perf_starve_cnt outputs.
// Revision : 1.0 - initial release
// ============================================================================
module nec_prefetch_queue #(
    parameter int DEPTH     = 8,
    parameter int BUS_BYTES = 2,
    parameter int WINDOW    = 6,
    parameter int CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    output logic                   fetch_req,
    output logic [15:0]            fetch_addr,
    input  logic                   fetch_ack,
    input  logic [8*BUS_BYTES-1:0] fetch_data,
    input  logic                   flush,
    input  logic [15:0]            flush_pc,
    output logic [8*WINDOW-1:0]    win_data,
    output logic [CNT_W-1:0]       win_count,
    input  logic                   consume,
    input  logic [CNT_W-1:0]       consume_count
`ifdef PREFETCH_PERF_EN
    ,
    output logic [15:0]            perf_flush_cnt,
    output logic [15:0]            perf_starve_cnt
`endif
);

    localparam int PTR_W = $clog2(DEPTH);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_REQ  = 1'b1;

    localparam logic [15:0] LANE_MASK = 16'(BUS_BYTES - 1);

    logic [0:0]       state_q,   state_d;
    logic [15:0]      addr_q,    addr_d;
    logic [15:0]      restart_q, restart_d;
    logic             discard_q, discard_d;
    logic [CNT_W-1:0] count_q,   count_d;
    logic [PTR_W-1:0] rd_ptr_q,  rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q,  wr_ptr_d;
    logic [7:0]       mem_q [DEPTH];

    logic [15:0]      w_lane;
    logic [PTR_W-1:0] w_off;
    logic [CNT_W-1:0] w_n;
    logic [CNT_W-1:0] w_free;
    logic             w_take;
    logic             w_cons;
    logic [CNT_W-1:0] w_add;
    logic [CNT_W-1:0] w_sub;

    // Lane offset of the current fetch address; an unaligned fetch only
    // delivers the upper lanes, so it yields fewer bytes.
    always_comb begin
        w_lane = fetch_addr & LANE_MASK;
        w_off  = w_lane[PTR_W-1:0];
        w_n    = CNT_W'(BUS_BYTES) - CNT_W'(w_lane);
        w_free = CNT_W'(DEPTH) - count_q;
        // A flush in the ack cycle drops the data, as does a discarded fetch.
        w_take = (state_q == S_REQ) && fetch_ack && !discard_q && !flush;
        w_cons = consume && !flush;
        w_add  = w_take ? w_n : '0;
        w_sub  = w_cons ? consume_count : '0;
    end

    // Next-state logic for the request FSM, pointers, count and fetch pointer.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        restart_d = restart_q;
        discard_d = discard_q;
        count_d   = count_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;

        if (flush) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            if ((state_q == S_REQ) && !fetch_ack) begin
                // Bus cycle still outstanding: keep the request (and its
                // address) up until the ack, then drop that data and restart.
                discard_d = 1'b1;
                restart_d = flush_pc;
            end else begin
                state_d   = S_IDLE;
                discard_d = 1'b0;
                addr_d    = flush_pc;
            end
        end else begin
            count_d = count_q + w_add - w_sub;
            if (w_take) begin
                wr_ptr_d = wr_ptr_q + w_n[PTR_W-1:0];
                addr_d   = addr_q + 16'(w_n);
            end
            if (w_cons) begin
                rd_ptr_d = rd_ptr_q + consume_count[PTR_W-1:0];
            end
            case (state_q)
                S_IDLE: begin
                    if (w_free >= CNT_W'(BUS_BYTES)) begin
                        state_d = S_REQ;
                    end
                end
                S_REQ: begin
                    if (fetch_ack) begin
                        state_d = S_IDLE;
                        if (discard_q) begin
                            discard_d = 1'b0;
                            addr_d    = restart_q;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Control state registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            restart_q <= '0;
            discard_q <= 1'b0;
            count_q   <= '0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            restart_q <= restart_d;
            discard_q <= discard_d;
            count_q   <= count_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
        end
    end

    // Byte storage: write the valid lanes of an accepted fetch at wr_ptr.
    always_ff @(posedge clk) begin
        if (w_take) begin
            for (int k = 0; k < BUS_BYTES; k++) begin
                if (PTR_W'(k) >= w_off) begin
                    mem_q[wr_ptr_q + PTR_W'(k) - w_off] <= fetch_data[8*k +: 8];
                end
            end
        end
    end

    // Pre-decoder window: bytes beyond the valid count read as zero.
    always_comb begin
        win_count = (count_q > CNT_W'(WINDOW)) ? CNT_W'(WINDOW) : count_q;
        win_data  = '0;
        for (int i = 0; i < WINDOW; i++) begin
            if (CNT_W'(i) < win_count) begin
                win_data[8*i +: 8] = mem_q[rd_ptr_q + PTR_W'(i)];
            end
        end
    end

    assign fetch_req  = (state_q == S_REQ);
    assign fetch_addr = addr_q;

    // The pre-decoder may only retire bytes that are actually in the window.
    a_consume_legal: assert property (@(posedge clk) disable iff (!reset_n)
        (consume && !flush) |-> (consume_count != '0 && consume_count <= win_count));

`ifdef PREFETCH_PERF_EN
    logic [15:0] perf_flush_q;
    logic [15:0] perf_starve_q;

    // Saturating event counters for flushes and window-starved fetch cycles.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            perf_flush_q  <= '0;
            perf_starve_q <= '0;
        end else begin
            if (flush && (perf_flush_q != 16'hFFFF)) begin
                perf_flush_q <= perf_flush_q + 16'd1;
            end
            if ((win_count == '0) && fetch_req && (perf_starve_q != 16'hFFFF)) begin
                perf_starve_q <= perf_starve_q + 16'd1;
            end
        end
    end

    assign perf_flush_cnt  = perf_flush_q;
    assign perf_starve_cnt = perf_starve_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_nec_prefetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_nec_prefetch_queue
// Brief    : Directed self-checking bench for nec_prefetch_queue (defaults
//            DEPTH=8, BUS_BYTES=2, WINDOW=6).
// Revision : 1.0 - initial release
// ============================================================================
module tb_nec_prefetch_queue;

    logic        clk;
    logic        reset_n;
    logic        fetch_req;
    logic [15:0] fetch_addr;
    logic        fetch_ack;
    logic [15:0] fetch_data;
    logic        flush;
    logic [15:0] flush_pc;
    logic [47:0] win_data;
    logic [3:0]  win_count;
    logic        consume;
    logic [3:0]  consume_count;
`ifdef PREFETCH_PERF_EN
    logic [15:0] perf_flush_cnt;
    logic [15:0] perf_starve_cnt;
`endif

    int checks;
    int failures;

    nec_prefetch_queue #(
        .DEPTH     (8),
        .BUS_BYTES (2),
        .WINDOW    (6)
    ) u_dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .fetch_req     (fetch_req),
        .fetch_addr    (fetch_addr),
        .fetch_ack     (fetch_ack),
        .fetch_data    (fetch_data),
        .flush         (flush),
        .flush_pc      (flush_pc),
        .win_data      (win_data),
        .win_count     (win_count),
        .consume       (consume),
        .consume_count (consume_count)
`ifdef PREFETCH_PERF_EN
        ,
        .perf_flush_cnt  (perf_flush_cnt),
        .perf_starve_cnt (perf_starve_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs driven and outputs sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input string tag);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 32; i++) begin
            if (fetch_req) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        check(tag, 64'(ok), 64'd1);
    endtask

    task automatic do_ack(input logic [15:0] d);
        fetch_ack  = 1'b1;
        fetch_data = d;
        tick();
        fetch_ack  = 1'b0;
        fetch_data = '0;
    endtask

    task automatic do_flush(input logic [15:0] pc);
        flush    = 1'b1;
        flush_pc = pc;
        tick();
        flush    = 1'b0;
    endtask

    function automatic logic [7:0] code_byte(input logic [15:0] a);
        return 8'(a * 16'd3) ^ a[15:8];
    endfunction

    logic [7:0]  mq[$];
    logic [15:0] ea;
    logic [47:0] ew;
    int          cc;
    int          sz;

    initial begin
        checks        = 0;
        failures      = 0;
        reset_n       = 1'b0;
        fetch_ack     = 1'b0;
        fetch_data    = '0;
        flush         = 1'b0;
        flush_pc      = '0;
        consume       = 1'b0;
        consume_count = '0;

        // ---- Reset state ----
        repeat (3) tick();
        check("rst_req",   64'(fetch_req),  64'd0);
        check("rst_addr",  64'(fetch_addr), 64'd0);
        check("rst_wcnt",  64'(win_count),  64'd0);
        check("rst_wdata", 64'(win_data),   64'd0);
        reset_n = 1'b1;

        // ---- 1: sequential fill from PFP 0 ----
        wait_req("t1_wait0");
        check("t1_addr0", 64'(fetch_addr), 64'h0000);
        do_ack(16'h3412);
        check("t1_wcnt0", 64'(win_count), 64'd2);
        check("t1_wdat0", 64'(win_data),  64'h3412);
        wait_req("t1_wait1");
        check("t1_addr1", 64'(fetch_addr), 64'h0002);
        do_ack(16'h7856);
        check("t1_wcnt1", 64'(win_count), 64'd4);
        wait_req("t1_wait2");
        check("t1_addr2", 64'(fetch_addr), 64'h0004);
        do_ack(16'hBC9A);
        check("t1_wcnt2", 64'(win_count), 64'd6);
        check("t1_wdat2", 64'(win_data),  64'hBC9A_7856_3412);

        // ---- 2: flush to odd address, single-byte fetch ----
        do_flush(16'h0101);
        check("t2_wcnt_fl", 64'(win_count), 64'd0);
        wait_req("t2_wait0");
        check("t2_addr0", 64'(fetch_addr), 64'h0101);
        do_ack(16'hEEFF);
        check("t2_wcnt", 64'(win_count), 64'd1);
        check("t2_wdat", 64'(win_data),  64'h00EE);
        wait_req("t2_wait1");
        check("t2_addr1", 64'(fetch_addr), 64'h0102);
        do_ack(16'h0000);

        // ---- 3: fill to full, no request while full ----
        do_flush(16'h0300);
        wait_req("t3_w0"); do_ack(16'h1100);
        wait_req("t3_w1"); do_ack(16'h3322);
        wait_req("t3_w2"); do_ack(16'h5544);
        wait_req("t3_w3"); do_ack(16'h7766);
        check("t3_wcnt_full", 64'(win_count), 64'd6);
        check("t3_wdat_full", 64'(win_data),  64'h5544_3322_1100);
        begin
            logic seen;
            seen = 1'b0;
            for (int i = 0; i < 4; i++) begin
                seen = seen | fetch_req;
                tick();
            end
            check("t3_noreq_full", 64'(seen), 64'd0);
        end
        consume       = 1'b1;
        consume_count = 4'd3;
        tick();
        consume       = 1'b0;
        consume_count = '0;
        check("t3_wcnt5", 64'(win_count), 64'd5);
        check("t3_wdat5", 64'(win_data),  64'h77_6655_4433);
        check("t3_req_lo", 64'(fetch_req), 64'd0);
        tick();
        check("t3_req_hi", 64'(fetch_req),  64'd1);
        check("t3_addr",   64'(fetch_addr), 64'h0308);

        // ---- 4: ack and consume in the same cycle at count 4 ----
        consume       = 1'b1;
        consume_count = 4'd1;
        tick();
        consume       = 1'b1;
        consume_count = 4'd2;
        check("t4_wcnt_pre", 64'(win_count), 64'd4);
        do_ack(16'h9988);
        consume       = 1'b0;
        consume_count = '0;
        check("t4_wcnt", 64'(win_count), 64'd4);
        check("t4_wdat", 64'(win_data),  64'h9988_7766);

        // ---- 5: flush while a request is outstanding ----
        do_flush(16'h0010);
        wait_req("t5_wait0");
        check("t5_addr_old", 64'(fetch_addr), 64'h0010);
        do_flush(16'h2000);
        check("t5_req_held",  64'(fetch_req),  64'd1);
        check("t5_addr_held", 64'(fetch_addr), 64'h0010);
        check("t5_wcnt0",     64'(win_count),  64'd0);
        tick();
        tick();
        do_ack(16'hAAAA);
        check("t5_wcnt_drop", 64'(win_count), 64'd0);
        check("t5_req_lo",    64'(fetch_req), 64'd0);
        wait_req("t5_wait1");
        check("t5_addr_new", 64'(fetch_addr), 64'h2000);
        check("t5_wcnt_new", 64'(win_count),  64'd0);

        // ---- 6: streaming fetch/consume across pointer wrap ----
        ea = 16'h2000;
        mq.delete();
        for (int f = 0; f < 20; f++) begin
            if (f != 0) wait_req("t6_wait");
            check("t6_addr", 64'(fetch_addr), 64'(ea));
            sz = mq.size();
            if (sz >= 5)      cc = 3;
            else if (sz >= 2) cc = (f % 2 != 0) ? 2 : 1;
            else              cc = sz;
            consume       = (cc != 0);
            consume_count = 4'(cc);
            do_ack({code_byte(ea + 16'd1), code_byte(ea)});
            consume       = 1'b0;
            consume_count = '0;
            for (int i = 0; i < cc; i++) void'(mq.pop_front());
            mq.push_back(code_byte(ea));
            mq.push_back(code_byte(ea + 16'd1));
            ea = ea + 16'd2;
            ew = '0;
            for (int i = 0; i < 6; i++) begin
                if (i < mq.size()) ew[8*i +: 8] = mq[i];
            end
            sz = (mq.size() > 6) ? 6 : mq.size();
            check("t6_wcnt", 64'(win_count), 64'(sz));
            check("t6_wdat", 64'(win_data),  64'(ew));
        end

        // ---- Reset while a request is outstanding ----
        wait_req("rst2_wait");
        reset_n = 1'b0;
        tick();
        check("rst2_req",  64'(fetch_req), 64'd0);
        check("rst2_wcnt", 64'(win_count), 64'd0);
        check("rst2_addr", 64'(fetch_addr), 64'd0);
        reset_n = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
